servant_uart_rx: RTL and testbench

- Serial receiver that consumes the servant GPIO output `q`, which the firmware bit-bangs as an 8N1 UART line.
- Decodes the line into bytes and buffers them in a small first-word-fall-through FIFO with a valid/ready output.
- Sits directly downstream of the servant SoC in the same `wb_clk` domain. Used for on-chip console capture and for self-checking benches.

---
 rtl/servant_uart_rx.sv | 158 +++++++++++++++
 tb/tb_servant_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_rx.sv
// 8N1 receiver for the servant GPIO console line, feeding a small
// first-word-fall-through FIFO with a valid/ready head.
//
// state   | meaning
// IDLE    | line high, waiting for a start edge
// START   | half-bit wait, then confirm start bit is still low
// DATA    | sample 8 data bits mid-bit, LSB first
// STOP    | sample stop bit; push, drop (overflow) or flag framing error
// BREAK   | line held low after a framing error; wait for it to go high
module servant_uart_rx #(
   parameter int frequency = 32,
   parameter int baud      = 115200,
   parameter int depth     = 4
) (
   input  logic                     wb_clk,
   input  logic                     wb_rst_n,
   input  logic                     i_rx,
   output logic [7:0]               o_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_frame_err,
   output logic                     o_overflow,
   output logic [$clog2(depth):0]   o_level
);

   localparam int DIV = (frequency * 1000000) / baud;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(depth);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      bitidx, bitidx_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            rx_meta, rx_s;
   logic            expire;
   logic            push, pop, full, can_accept;
   logic            ferr_nxt, ovf_nxt;

   logic [7:0]      mem [depth];
   logic [AW:0]     wr_ptr, rd_ptr;

   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   assign expire = (cnt == '0);

   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         bitidx <= '0;
         shreg  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         bitidx <= bitidx_nxt;
         shreg  <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = expire ? '0 : cnt - 1'b1;
      bitidx_nxt = bitidx;
      shreg_nxt  = shreg;
      push       = 1'b0;
      ferr_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nxt = S_START;
               cnt_nxt   = CNT_HALF;
            end
         end
         S_START: begin
            if (expire) begin
               if (!rx_s) begin
                  state_nxt  = S_DATA;
                  cnt_nxt    = CNT_FULL;
                  bitidx_nxt = '0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (expire) begin
               shreg_nxt = {rx_s, shreg[7:1]};
               cnt_nxt   = CNT_FULL;
               if (bitidx == 3'd7) state_nxt = S_STOP;
               else                bitidx_nxt = bitidx + 3'd1;
            end
         end
         S_STOP: begin
            if (expire) begin
               if (rx_s) begin
                  if (can_accept) push = 1'b1;
                  else            ovf_nxt = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign pop        = o_valid && i_ready;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign can_accept = !full || pop;

   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_frame_err <= 1'b0;
         o_overflow  <= 1'b0;
         for (int i = 0; i < depth; i++) mem[i] <= '0;
      end else begin
         o_frame_err <= ferr_nxt;
         o_overflow  <= ovf_nxt;
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign o_valid = (wr_ptr != rd_ptr);
   assign o_data  = mem[rd_ptr[AW-1:0]];
   assign o_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx at 10 clocks per bit: vector table of
// whole frames plus hand sequences for glitch, framing error, drain and reset.
module tb_servant_uart_rx;

   localparam int DIV = 10;

   logic       wb_clk   = 1'b0;
   logic       wb_rst_n = 1'b0;
   logic       i_rx     = 1'b1;
   logic       i_ready  = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overflow;
   logic [2:0] o_level;

   servant_uart_rx #(.frequency(1), .baud(100000), .depth(4)) dut (
      .wb_clk      (wb_clk),
      .wb_rst_n    (wb_rst_n),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overflow  (o_overflow),
      .o_level     (o_level)
   );

   always #5 wb_clk = ~wb_clk;

   int n_checks = 0;
   int n_pass   = 0;

   int fe_cycles   = 0;
   int ov_cycles   = 0;
   int both_cycles = 0;
   int max_level   = 0;

   always @(negedge wb_clk) begin
      if (o_frame_err) fe_cycles++;
      if (o_overflow) ov_cycles++;
      if (o_frame_err && o_overflow) both_cycles++;
      if (int'(o_level) > max_level) max_level = int'(o_level);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   // Start bit is driven right after an edge; the stop sample then falls in
   // the cycle 97 edges later and the push is visible after edge 98.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic pulse_ready,
                             output int pre_level, output int post_valid, output int post_data,
                             output int post_level, output int post_fe, output int post_ov);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 9; i++) begin
         i_rx = bits[i];
         repeat (DIV) tick();
      end
      i_rx = stop;
      repeat (7) tick();
      pre_level = int'(o_level);
      if (pulse_ready) i_ready = 1'b1;
      tick();
      if (pulse_ready) i_ready = 1'b0;
      post_valid = int'(o_valid);
      post_data  = int'(o_data);
      post_level = int'(o_level);
      post_fe    = int'(o_frame_err);
      post_ov    = int'(o_overflow);
      repeat (2) tick();
   endtask

   typedef struct {
      logic [7:0] data;
      logic       ready;
      logic       pulse;
      int         pre_level;
      int         post_valid;
      int         post_data;
      int         post_level;
      int         fe;
      int         ov;
   } vec_t;

   vec_t vecs [12];

   task automatic run_vec(input int i);
      int pl, pv, pd, pll, pf, po;
      i_ready = vecs[i].ready;
      send_frame(vecs[i].data, 1'b1, vecs[i].pulse, pl, pv, pd, pll, pf, po);
      check($sformatf("v%0d pre_level", i), pl, vecs[i].pre_level);
      check($sformatf("v%0d valid", i), pv, vecs[i].post_valid);
      check($sformatf("v%0d data", i), pd, vecs[i].post_data);
      check($sformatf("v%0d level", i), pll, vecs[i].post_level);
      check($sformatf("v%0d frame_err", i), pf, vecs[i].fe);
      check($sformatf("v%0d overflow", i), po, vecs[i].ov);
   endtask

   task automatic drain4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
      logic [7:0] exp_d [4];
      exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain%0d valid", k), int'(o_valid), 1);
         check($sformatf("drain%0d data", k), int'(o_data), int'(exp_d[k]));
         check($sformatf("drain%0d level", k), int'(o_level), 4 - k);
         tick();
      end
      check("drain empty valid", int'(o_valid), 0);
      check("drain empty level", int'(o_level), 0);
      i_ready = 1'b0;
   endtask

   initial begin
      int pl, pv, pd, pll, pf, po;
      logic [9:0] bits;

      //           data   rdy   pulse pre vld data   lvl fe ov
      vecs[0]  = '{8'h55, 1'b1, 1'b0, 0,  1,  8'h55, 1,  0, 0};
      vecs[1]  = '{8'hA3, 1'b1, 1'b0, 0,  1,  8'hA3, 1,  0, 0};
      vecs[2]  = '{8'h01, 1'b0, 1'b0, 0,  1,  8'h01, 1,  0, 0};
      vecs[3]  = '{8'h02, 1'b0, 1'b0, 1,  1,  8'h01, 2,  0, 0};
      vecs[4]  = '{8'h03, 1'b0, 1'b0, 2,  1,  8'h01, 3,  0, 0};
      vecs[5]  = '{8'h04, 1'b0, 1'b0, 3,  1,  8'h01, 4,  0, 0};
      vecs[6]  = '{8'h05, 1'b0, 1'b0, 4,  1,  8'h01, 4,  0, 1};
      vecs[7]  = '{8'h11, 1'b0, 1'b0, 0,  1,  8'h11, 1,  0, 0};
      vecs[8]  = '{8'h22, 1'b0, 1'b0, 1,  1,  8'h11, 2,  0, 0};
      vecs[9]  = '{8'h33, 1'b0, 1'b0, 2,  1,  8'h11, 3,  0, 0};
      vecs[10] = '{8'h44, 1'b0, 1'b0, 3,  1,  8'h11, 4,  0, 0};
      vecs[11] = '{8'h99, 1'b0, 1'b1, 4,  1,  8'h22, 4,  0, 0};

      repeat (3) tick();
      check("reset valid", int'(o_valid), 0);
      check("reset data", int'(o_data), 0);
      check("reset level", int'(o_level), 0);
      check("reset frame_err", int'(o_frame_err), 0);
      check("reset overflow", int'(o_overflow), 0);
      wb_rst_n = 1'b1;
      repeat (3) tick();
      max_level = 0;

      for (int i = 0; i < 2; i++) run_vec(i);
      check("basic max_level", max_level, 1);

      for (int i = 2; i < 7; i++) run_vec(i);
      drain4(8'h01, 8'h02, 8'h03, 8'h04);

      for (int i = 7; i < 12; i++) run_vec(i);
      drain4(8'h22, 8'h33, 8'h44, 8'h99);

      // Short low glitch must be rejected at the mid-start sample.
      i_ready = 1'b1;
      i_rx = 1'b0;
      repeat (3) tick();
      i_rx = 1'b1;
      repeat (20) tick();
      check("glitch valid", int'(o_valid), 0);
      check("glitch level", int'(o_level), 0);
      send_frame(8'h3C, 1'b1, 1'b0, pl, pv, pd, pll, pf, po);
      check("after glitch valid", pv, 1);
      check("after glitch data", pd, 8'h3C);
      check("after glitch frame_err", pf, 0);

      send_frame(8'hA3, 1'b0, 1'b0, pl, pv, pd, pll, pf, po);
      check("ferr pulse", pf, 1);
      check("ferr overflow", po, 0);
      check("ferr valid", pv, 0);
      check("ferr level", pll, 0);
      repeat (40) tick();
      check("ferr single pulse", fe_cycles, 1);
      check("break level", int'(o_level), 0);
      i_rx = 1'b1;
      repeat (10) tick();
      send_frame(8'h7E, 1'b1, 1'b0, pl, pv, pd, pll, pf, po);
      check("after break valid", pv, 1);
      check("after break data", pd, 8'h7E);
      check("after break frame_err", pf, 0);

      i_ready = 1'b0;
      send_frame(8'h10, 1'b1, 1'b0, pl, pv, pd, pll, pf, po);
      send_frame(8'h20, 1'b1, 1'b0, pl, pv, pd, pll, pf, po);
      check("pre-reset level", int'(o_level), 2);
      bits = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         i_rx = bits[i];
         repeat (DIV) tick();
      end
      i_rx = bits[5];
      repeat (5) tick();
      wb_rst_n = 1'b0;
      tick();
      wb_rst_n = 1'b1;
      check("midreset valid", int'(o_valid), 0);
      check("midreset level", int'(o_level), 0);
      i_rx = 1'b1;
      repeat (50) tick();
      check("post-reset idle valid", int'(o_valid), 0);
      i_ready = 1'b1;
      send_frame(8'h42, 1'b1, 1'b0, pl, pv, pd, pll, pf, po);
      check("post-reset pre_level", pl, 0);
      check("post-reset valid", pv, 1);
      check("post-reset data", pd, 8'h42);

      repeat (5) tick();
      check("total frame_err cycles", fe_cycles, 1);
      check("total overflow cycles", ov_cycles, 1);
      check("flags together", both_cycles, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
